// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter
// -------------
// Collects results from NUM_CH functional units into per-channel FIFOs and
// retires at most one of them per cycle onto a single registered ROB
// writeback port. Channels are served round-robin, starting one past the
// most recently granted channel. Per-channel result order is preserved.
//
// Ports
//   in_clk                 sole clock, all state changes on the rising edge
//   in_rst                 synchronous active-high reset (beats in_flush)
//   in_flush               mispredict flush, discards every buffered result
//   in_fu_valid[NUM_CH]    per-channel result valid
//   in_fu_value            per-channel value, channel i at [i*VAL_W +: VAL_W]
//   in_fu_rob_index        per-channel ROB index, packed the same way
//   in_fu_set_nzcv         per-channel "result writes NZCV" flag
//   in_fu_nzcv             per-channel NZCV value, 4 bits per channel
//   in_fu_cond             per-channel condition-holds bit
//   out_fu_ready[NUM_CH]   per-channel buffer has room (registered state only)
//   in_rob_stall           ROB cannot take a writeback, everything holds
//   out_rob_*              registered writeback port, qualified by out_rob_done
//   out_alu_condition      condition bit of the retired result
//   out_overflow           sticky: a result arrived on a full channel and was lost
//   out_busy               a result is buffered or being presented

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 5
`endif

module fu_wb_arbiter #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    parameter int VAL_W  = `GPR_SIZE,
    parameter int IDX_W  = `ROB_IDX_SIZE
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_flush,
    input  logic [NUM_CH-1:0]       in_fu_valid,
    input  logic [NUM_CH*VAL_W-1:0] in_fu_value,
    input  logic [NUM_CH*IDX_W-1:0] in_fu_rob_index,
    input  logic [NUM_CH-1:0]       in_fu_set_nzcv,
    input  logic [NUM_CH*4-1:0]     in_fu_nzcv,
    input  logic [NUM_CH-1:0]       in_fu_cond,
    output logic [NUM_CH-1:0]       out_fu_ready,
    input  logic                    in_rob_stall,
    output logic                    out_rob_done,
    output logic [IDX_W-1:0]        out_rob_dst_rob_index,
    output logic [VAL_W-1:0]        out_rob_value,
    output logic                    out_rob_set_nzcv,
    output logic [3:0]              out_rob_nzcv,
    output logic                    out_alu_condition,
    output logic                    out_overflow,
    output logic                    out_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GNT_W = $clog2(NUM_CH);

    // Per-channel result storage, one array per entry field.
    logic [VAL_W-1:0] mem_value    [NUM_CH][DEPTH];
    logic [IDX_W-1:0] mem_rob_index[NUM_CH][DEPTH];
    logic             mem_set_nzcv [NUM_CH][DEPTH];
    logic [3:0]       mem_nzcv     [NUM_CH][DEPTH];
    logic             mem_cond     [NUM_CH][DEPTH];

    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [CNT_W-1:0] count  [NUM_CH];

    logic [GNT_W-1:0] last_grant;

    logic [NUM_CH-1:0] has_room;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              grant_valid;
    logic [GNT_W-1:0]  grant_ch;
    logic              any_buffered;

    // Room is judged from the registered count alone: a pop in the same
    // cycle never frees space for a push on a full channel.
    always_comb begin
        has_room = '0;
        push     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            has_room[i] = (count[i] < CNT_W'(DEPTH));
            push[i]     = in_fu_valid[i] && has_room[i];
        end
    end

    // During reset the buffers are being emptied, so advertise room on all
    // channels regardless of what the counters held before the reset edge.
    assign out_fu_ready = has_room | {NUM_CH{in_rst}};

    // Round-robin pick: walk the channels starting one past last_grant and
    // take the first that holds a result. A stalled ROB suppresses the grant.
    always_comb begin
        int               cand;
        logic [GNT_W-1:0] cand_ch;
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = 0;
        cand_ch     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_ch = GNT_W'(cand);
            if (!grant_valid && (count[cand_ch] != '0)) begin
                grant_valid = 1'b1;
                grant_ch    = cand_ch;
            end
        end
        if (in_rob_stall) begin
            grant_valid = 1'b0;
        end
    end

    // Decode the grant into per-channel pop strobes.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant_valid && (grant_ch == GNT_W'(i));
        end
    end

    // Busy covers both buffered results and the one on the writeback port.
    always_comb begin
        any_buffered = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (count[i] != '0) begin
                any_buffered = 1'b1;
            end
        end
    end

    assign out_busy = any_buffered || out_rob_done;

    // FIFO bookkeeping, arbitration state and the writeback registers.
    // Reset wins over flush; flush wins over push, pop and stall but keeps
    // the round-robin position and the sticky overflow flag. Storage arrays
    // are never cleared because an entry is only read after being written.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            last_grant            <= GNT_W'(NUM_CH - 1);
            out_rob_done          <= 1'b0;
            out_rob_dst_rob_index <= '0;
            out_rob_value         <= '0;
            out_rob_set_nzcv      <= 1'b0;
            out_rob_nzcv          <= '0;
            out_alu_condition     <= 1'b0;
            out_overflow          <= 1'b0;
        end else if (in_flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            out_rob_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    mem_value[i][wr_ptr[i]]     <= in_fu_value[i*VAL_W +: VAL_W];
                    mem_rob_index[i][wr_ptr[i]] <= in_fu_rob_index[i*IDX_W +: IDX_W];
                    mem_set_nzcv[i][wr_ptr[i]]  <= in_fu_set_nzcv[i];
                    mem_nzcv[i][wr_ptr[i]]      <= in_fu_nzcv[i*4 +: 4];
                    mem_cond[i][wr_ptr[i]]      <= in_fu_cond[i];
                    wr_ptr[i]                   <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end

            if ((in_fu_valid & ~has_room) != '0) begin
                out_overflow <= 1'b1;
            end

            if (!in_rob_stall) begin
                if (grant_valid) begin
                    out_rob_done          <= 1'b1;
                    out_rob_value         <= mem_value[grant_ch][rd_ptr[grant_ch]];
                    out_rob_dst_rob_index <= mem_rob_index[grant_ch][rd_ptr[grant_ch]];
                    out_rob_set_nzcv      <= mem_set_nzcv[grant_ch][rd_ptr[grant_ch]];
                    out_rob_nzcv          <= mem_nzcv[grant_ch][rd_ptr[grant_ch]];
                    out_alu_condition     <= mem_cond[grant_ch][rd_ptr[grant_ch]];
                    last_grant            <= grant_ch;
                end else begin
                    out_rob_done <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter with two channels of depth four.
// A queue-based reference model tracks what the writeback port must show;
// a compare process checks it every cycle and directed scenarios add
// hand-computed literal checks.

module tb_fu_wb_arbiter;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int VAL_W  = 16;
    localparam int IDX_W  = 5;

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [IDX_W-1:0] idx;
        logic             setn;
        logic [3:0]       nzcv;
        logic             cond;
    } entry_t;

    logic                    in_clk;
    logic                    in_rst;
    logic                    in_flush;
    logic [NUM_CH-1:0]       in_fu_valid;
    logic [NUM_CH*VAL_W-1:0] in_fu_value;
    logic [NUM_CH*IDX_W-1:0] in_fu_rob_index;
    logic [NUM_CH-1:0]       in_fu_set_nzcv;
    logic [NUM_CH*4-1:0]     in_fu_nzcv;
    logic [NUM_CH-1:0]       in_fu_cond;
    logic [NUM_CH-1:0]       out_fu_ready;
    logic                    in_rob_stall;
    logic                    out_rob_done;
    logic [IDX_W-1:0]        out_rob_dst_rob_index;
    logic [VAL_W-1:0]        out_rob_value;
    logic                    out_rob_set_nzcv;
    logic [3:0]              out_rob_nzcv;
    logic                    out_alu_condition;
    logic                    out_overflow;
    logic                    out_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    entry_t mq [NUM_CH][$];
    int     m_last;
    bit     m_done;
    entry_t m_out;
    bit     m_ovf;

    fu_wb_arbiter #(
        .NUM_CH(NUM_CH),
        .DEPTH (DEPTH),
        .VAL_W (VAL_W),
        .IDX_W (IDX_W)
    ) dut (
        .in_clk               (in_clk),
        .in_rst               (in_rst),
        .in_flush             (in_flush),
        .in_fu_valid          (in_fu_valid),
        .in_fu_value          (in_fu_value),
        .in_fu_rob_index      (in_fu_rob_index),
        .in_fu_set_nzcv       (in_fu_set_nzcv),
        .in_fu_nzcv           (in_fu_nzcv),
        .in_fu_cond           (in_fu_cond),
        .out_fu_ready         (out_fu_ready),
        .in_rob_stall         (in_rob_stall),
        .out_rob_done         (out_rob_done),
        .out_rob_dst_rob_index(out_rob_dst_rob_index),
        .out_rob_value        (out_rob_value),
        .out_rob_set_nzcv     (out_rob_set_nzcv),
        .out_rob_nzcv         (out_rob_nzcv),
        .out_alu_condition    (out_alu_condition),
        .out_overflow         (out_overflow),
        .out_busy             (out_busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue per channel, round-robin pick from the
    // pre-edge occupancy, pushes only into queues that were not full.
    always @(posedge in_clk) begin
        entry_t e;
        int     g;
        if (in_rst) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_last = NUM_CH - 1;
            m_done = 1'b0;
            m_out  = '0;
            m_ovf  = 1'b0;
        end else if (in_flush) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            m_done = 1'b0;
        end else begin
            g = -1;
            if (!in_rob_stall) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    int c;
                    c = (m_last + k) % NUM_CH;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_fu_valid[c]) begin
                    if (mq[c].size() < DEPTH) begin
                        e.val  = in_fu_value[c*VAL_W +: VAL_W];
                        e.idx  = in_fu_rob_index[c*IDX_W +: IDX_W];
                        e.setn = in_fu_set_nzcv[c];
                        e.nzcv = in_fu_nzcv[c*4 +: 4];
                        e.cond = in_fu_cond[c];
                        mq[c].push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!in_rob_stall) begin
                if (g >= 0) begin
                    m_out  = mq[g].pop_front();
                    m_done = 1'b1;
                    m_last = g;
                end else begin
                    m_done = 1'b0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge in_clk) begin
        if (chk_en) begin
            logic [NUM_CH-1:0] exp_ready;
            bit                exp_busy;
            exp_busy = m_done;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_ready[c] = in_rst || (mq[c].size() < DEPTH);
                if (mq[c].size() > 0) exp_busy = 1'b1;
            end
            checkOutput("done",     64'(out_rob_done),          64'(m_done));
            checkOutput("value",    64'(out_rob_value),         64'(m_out.val));
            checkOutput("rob_idx",  64'(out_rob_dst_rob_index), 64'(m_out.idx));
            checkOutput("set_nzcv", 64'(out_rob_set_nzcv),      64'(m_out.setn));
            checkOutput("nzcv",     64'(out_rob_nzcv),          64'(m_out.nzcv));
            checkOutput("cond",     64'(out_alu_condition),     64'(m_out.cond));
            checkOutput("ready",    64'(out_fu_ready),          64'(exp_ready));
            checkOutput("overflow", 64'(out_overflow),          64'(m_ovf));
            checkOutput("busy",     64'(out_busy),              64'(exp_busy));
        end
    end

    // Drive one cycle's inputs; side fields are derived from the value.
    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [VAL_W-1:0] v0, input logic [IDX_W-1:0] i0,
                                 input logic [VAL_W-1:0] v1, input logic [IDX_W-1:0] i1,
                                 input logic stall, input logic flush, input logic rst);
        in_fu_valid     = valid;
        in_fu_value     = {v1, v0};
        in_fu_rob_index = {i1, i0};
        in_fu_set_nzcv  = {v1[1], v0[1]};
        in_fu_nzcv      = {v1[7:4], v0[7:4]};
        in_fu_cond      = {v1[0] ^ v1[2], v0[0]};
        in_rob_stall    = stall;
        in_flush        = flush;
        in_rst          = rst;
    endtask

    task automatic step();
        @(posedge in_clk);
        @(negedge in_clk);
        #1;
    endtask

    task automatic idle(input logic stall);
        applyStimulus(2'b00, '0, '0, '0, '0, stall, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        idle(1'b0);
    endtask

    // Release the stall and count retirements until the block goes idle.
    task automatic drain(output int drained);
        int n;
        drained = 0;
        n = 0;
        idle(1'b0);
        while (out_busy && n < 20) begin
            step();
            n++;
            if (out_rob_done) drained++;
        end
        if (out_busy) $display("[TB] FAIL drain_timeout: busy=%0d after %0d cycles, required 0", out_busy, n);
    endtask

    initial begin
        int drained;

        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk_en = 1'b1;
        step();
        checkOutput("reset_ready", 64'(out_fu_ready), 64'h3);
        idle(1'b0);
        step();
        checkOutput("reset_done", 64'(out_rob_done), 64'h0);
        checkOutput("reset_busy", 64'(out_busy), 64'h0);

        // Single result through channel 0: one-cycle latency, one-cycle pulse
        $display("[TB] single result latency");
        applyStimulus(2'b01, 16'd5, 5'd3, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        step();
        checkOutput("lat_done", 64'(out_rob_done), 64'h1);
        checkOutput("lat_value", 64'(out_rob_value), 64'h5);
        checkOutput("lat_idx", 64'(out_rob_dst_rob_index), 64'h3);
        step();
        checkOutput("lat_done_clear", 64'(out_rob_done), 64'h0);

        // Both channels every cycle: ch0, ch1, ch0 order after reset
        $display("[TB] alternating grants");
        doReset();
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2'b11, VAL_W'(16'h100 + n), IDX_W'(n), VAL_W'(16'h200 + n), IDX_W'(n + 8),
                          1'b0, 1'b0, 1'b0);
            step();
            if (n == 1) checkOutput("alt_first", 64'(out_rob_value), 64'h100);
            if (n == 2) checkOutput("alt_second", 64'(out_rob_value), 64'h200);
        end
        idle(1'b0);
        step();
        checkOutput("alt_third", 64'(out_rob_value), 64'h101);
        drain(drained);
        checkOutput("alt_drained", 64'(drained), 64'd3);

        // Fill channel 1 under stall, overflow it, then drain
        $display("[TB] fill and overflow");
        doReset();
        for (int n = 0; n < DEPTH; n++) begin
            applyStimulus(2'b10, '0, '0, VAL_W'(16'h300 + n), IDX_W'(n), 1'b1, 1'b0, 1'b0);
            step();
        end
        checkOutput("full_ready1", 64'(out_fu_ready[1]), 64'h0);
        checkOutput("full_no_ovf", 64'(out_overflow), 64'h0);
        applyStimulus(2'b10, '0, '0, 16'h3ff, 5'd31, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("ovf_set", 64'(out_overflow), 64'h1);
        drain(drained);
        checkOutput("full_drained", 64'(drained), 64'(DEPTH));

        // Stall while a result is presented: outputs freeze, nothing lost
        $display("[TB] stall freeze");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2'b01, VAL_W'(16'h400 + n), IDX_W'(n + 4), '0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
        idle(1'b0);
        step();
        checkOutput("frz_first", 64'(out_rob_value), 64'h400);
        for (int n = 0; n < 3; n++) begin
            idle(1'b1);
            step();
            checkOutput("frz_done", 64'(out_rob_done), 64'h1);
            checkOutput("frz_value", 64'(out_rob_value), 64'h400);
        end
        drain(drained);
        checkOutput("frz_drained", 64'(drained), 64'd2);

        // Flush with three buffered and a same-edge ch0 push
        $display("[TB] flush");
        applyStimulus(2'b11, 16'h500, 5'd1, 16'h510, 5'd2, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(2'b01, 16'h501, 5'd3, '0, '0, 1'b0, 1'b0, 1'b0);
        step();
        applyStimulus(2'b11, 16'h502, 5'd4, 16'h511, 5'd5, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("pre_flush_done", 64'(out_rob_done), 64'h1);
        applyStimulus(2'b01, 16'h5ff, 5'd6, '0, '0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("flush_done", 64'(out_rob_done), 64'h0);
        checkOutput("flush_busy", 64'(out_busy), 64'h0);
        checkOutput("flush_ready", 64'(out_fu_ready), 64'h3);
        checkOutput("flush_keeps_ovf", 64'(out_overflow), 64'h1);
        idle(1'b0);
        step();
        checkOutput("flush_discard", 64'(out_rob_done), 64'h0);

        // Reset together with flush in the middle of a drain
        $display("[TB] reset mid-drain");
        applyStimulus(2'b11, 16'h600, 5'd7, 16'h700, 5'd8, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        step();
        checkOutput("mid_done", 64'(out_rob_done), 64'h1);
        applyStimulus(2'b11, 16'h6ff, 5'd9, 16'h7ff, 5'd10, 1'b0, 1'b1, 1'b1);
        step();
        checkOutput("rst_done", 64'(out_rob_done), 64'h0);
        checkOutput("rst_value", 64'(out_rob_value), 64'h0);
        checkOutput("rst_ovf", 64'(out_overflow), 64'h0);
        checkOutput("rst_busy", 64'(out_busy), 64'h0);
        applyStimulus(2'b11, 16'h800, 5'd11, 16'h900, 5'd12, 1'b0, 1'b0, 1'b0);
        step();
        idle(1'b0);
        step();
        checkOutput("rst_prio_ch0", 64'(out_rob_value), 64'h800);
        drain(drained);
        checkOutput("rst_drained", 64'(drained), 64'd1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of functional-unit result channels (>=2).
REQ-002 Parameter DEPTH, default 4, result buffer entries per channel (power of 2, >=2).
REQ-003 Parameter VAL_W, default `GPR_SIZE, result value width.
REQ-004 Parameter IDX_W, default `ROB_IDX_SIZE, ROB index width.
REQ-005 in_clk  input  1  sole clock; all state updates on posedge.
REQ-006 in_rst  input  1  synchronous active-high reset.
REQ-007 in_flush  input  1  mispredict flush; discards all buffered results.
REQ-008 in_fu_valid  input  NUM_CH  per-channel result valid.
REQ-009 in_fu_value  input  NUM_CH*VAL_W  per-channel result value; channel i occupies bits [i*VAL_W +: VAL_W].
REQ-010 in_fu_rob_index  input  NUM_CH*IDX_W  per-channel destination ROB index, packed the same way.
REQ-011 in_fu_set_nzcv  input  NUM_CH  per-channel NZCV-write flag.
REQ-012 in_fu_nzcv  input  NUM_CH*4  per-channel NZCV value.
REQ-013 in_fu_cond  input  NUM_CH  per-channel condition-holds bit.
REQ-014 out_fu_ready  output  NUM_CH  per-channel buffer not full.
REQ-015 in_rob_stall  input  1  ROB cannot accept a writeback this cycle.
REQ-016 out_rob_done, out_rob_dst_rob_index (IDX_W), out_rob_value (VAL_W), out_rob_set_nzcv (1), out_rob_nzcv (4), out_alu_condition (1)  outputs  registered single writeback port.
REQ-017 out_overflow  output  1  sticky: a valid arrived on a full channel.
REQ-018 out_busy  output  1  any buffer non-empty or out_rob_done high.

Function
REQ-019 Each channel SHALL own a DEPTH-entry FIFO of {value, rob_index, set_nzcv, nzcv, cond} with wrap-around read/write pointers and a count of width clog2(DEPTH)+1.
REQ-020 out_fu_ready[i] SHALL be (count[i] < DEPTH), from registered state only; no same-cycle pop bypass.
REQ-021 Enqueue on channel i SHALL occur when in_fu_valid[i] & out_fu_ready[i]; all channels may enqueue in the same cycle.
REQ-022 in_fu_valid[i] while channel i is full SHALL drop the result and set out_overflow until reset.
REQ-023 When in_rob_stall is low, exactly one non-empty channel SHALL be granted per cycle: search starts at last_grant+1 mod NUM_CH, first non-empty wins.
REQ-024 last_grant SHALL update only on a grant; no grant when all FIFOs are empty.
REQ-025 On grant, the head entry SHALL be popped and loaded into the output registers, with out_rob_done <= 1 at the same edge.
REQ-026 With no grant and in_rob_stall low, out_rob_done SHALL be 0 at the next edge; the other outputs hold.
REQ-027 With in_rob_stall high, no pop SHALL occur and all output registers SHALL hold, including out_rob_done.
REQ-028 Minimum latency: a result enqueued at edge k SHALL appear with out_rob_done=1 after edge k+1.
REQ-029 Simultaneous push and pop on a full channel SHALL NOT be accepted (see REQ-020); push and pop on a non-full channel SHALL leave count unchanged.
REQ-030 Per-channel result order SHALL be preserved; cross-channel order is arbitration order.
REQ-031 in_flush SHALL zero all counts and pointers and clear out_rob_done at the same edge; it takes priority over same-edge enqueue, grant and stall.
REQ-032 in_flush SHALL leave last_grant and out_overflow unchanged.

Reset
REQ-033 in_rst SHALL override in_flush and all other inputs.
REQ-034 On in_rst: all counts and pointers = 0; last_grant = NUM_CH-1, so channel 0 has first priority; out_rob_done = 0; all other output registers = 0; out_overflow = 0.
REQ-035 While in reset, out_fu_ready SHALL read all ones (buffers empty); inputs are ignored.

Verification
REQ-036 Reset, then ch0 valid value=5 idx=3 at edge 1 -> out_rob_done=1, value=5, idx=3 after edge 2, and 0 after edge 3.
REQ-037 Both channels valid every cycle, NUM_CH=2, no stall -> grants alternate ch0,ch1,ch0,...; one done per cycle; per-channel FIFO order kept.
REQ-038 Fill ch1 with DEPTH entries under in_rob_stall=1 -> out_fu_ready[1]=0; one more valid sets out_overflow=1; releasing the stall drains exactly DEPTH entries.
REQ-039 Stall asserted while out_rob_done=1 -> outputs frozen for the stall duration; no entry is lost or duplicated.
REQ-040 in_flush with 3 entries buffered and ch0 valid on the same edge -> all counts 0, out_rob_done=0 next cycle, ch0 input discarded, out_busy=0.
REQ-041 in_rst asserted mid-drain together with in_flush -> the reset values of REQ-034 apply at that edge, out_overflow cleared.
